serial_xnor_checker: RTL



---
 rtl/serial_xnor_checker.sv | 112 +++++++++++
 1 files changed

// File: rtl/serial_xnor_checker.sv
// Bit-serial equality checker: accumulates per-bit XNOR results over a WIDTH-bit
// frame and reports whole-word equality, mismatch count and first mismatch index.
module serial_xnor_checker #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1),
  localparam int IW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bit_valid,
  input  logic          xnor_bit,
  output logic          busy,
  output logic          done,
  output logic          equal,
  output logic [CW-1:0] mismatch_count,
  output logic [IW-1:0] first_mismatch,
  output logic [IW-1:0] bit_index
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t        state, state_nxt;
  logic          busy_nxt, done_nxt, equal_nxt, seen, seen_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [IW-1:0] first_nxt, idx_nxt;

  // Count never exceeds WIDTH, which CW bits always hold.
  function automatic logic [CW-1:0] count_inc(input logic [CW-1:0] c);
    return c + CW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      equal          <= 1'b0;
      seen           <= 1'b0;
      mismatch_count <= '0;
      first_mismatch <= '0;
      bit_index      <= '0;
    end else begin
      state          <= state_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      equal          <= equal_nxt;
      seen           <= seen_nxt;
      mismatch_count <= cnt_nxt;
      first_mismatch <= first_nxt;
      bit_index      <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    equal_nxt = equal;
    seen_nxt  = seen;
    cnt_nxt   = mismatch_count;
    first_nxt = first_mismatch;
    idx_nxt   = bit_index;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          busy_nxt  = 1'b1;
          equal_nxt = 1'b1;
          seen_nxt  = 1'b0;
          cnt_nxt   = '0;
          first_nxt = '0;
          idx_nxt   = '0;
        end
      end
      RUN: begin
        if (bit_valid) begin
          if (!xnor_bit) begin
            cnt_nxt   = count_inc(mismatch_count);
            equal_nxt = 1'b0;
            if (!seen) begin
              first_nxt = bit_index;
              seen_nxt  = 1'b1;
            end
          end
          // The index parks on the last bit instead of wrapping.
          if (bit_index == LAST_IDX) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = bit_index + IW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
